// File: rtl/weight_write_pkg.sv
// Shared types for the weight/bias buffer write controller: command record,
// error bit positions and controller states.
package weight_write_pkg;

   // Command field widths for the standard configuration
   // (4 line buffers, 512x8 words per line buffer).
   localparam int PKG_LB_COUNT = 4;
   localparam int PKG_ADDR_W   = 12;
   localparam int PKG_CNT_W    = 13;

   typedef struct packed {
      logic                    bias;
      logic [PKG_LB_COUNT-1:0] mask;
      logic [PKG_ADDR_W-1:0]   base_addr;
      logic [PKG_CNT_W-1:0]    word_count;
   } cmd_t;

   // Bit positions inside o_error.
   localparam int ERR_LENGTH = 0;
   localparam int ERR_WRAP   = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/weight_write_addr_gen.sv
// Loadable linear word address counter with a burst remaining counter.
// In short mode (bias target) the address wraps inside the low SAW bits.
module weight_write_addr_gen #(
   parameter int AW  = 12,
   parameter int SAW = 7,
   parameter int CW  = 13
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          short_mode,
   input  logic [AW-1:0] load_addr,
   input  logic [CW-1:0] load_count,
   input  logic          step,
   output logic [AW-1:0] addr,
   output logic          last_word,
   output logic          wrap_flag
);

   localparam logic [AW-1:0] SHORT_MAX = AW'((64'd1 << SAW) - 64'd1);

   logic [AW-1:0] addr_reg;
   logic [CW-1:0] remaining_reg;
   logic          wrap_reg;
   logic          short_reg;
   logic [AW-1:0] top_addr;
   logic          at_top;

   assign top_addr  = short_reg ? SHORT_MAX : {AW{1'b1}};
   assign at_top    = (addr_reg == top_addr);
   assign addr      = addr_reg;
   assign last_word = (remaining_reg == CW'(1));
   // Sticky wrap, including a wrap caused by the step happening this cycle.
   assign wrap_flag = wrap_reg | (step & at_top);

   // Load on command accept, then advance address and remaining count per beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_reg      <= '0;
         remaining_reg <= '0;
         wrap_reg      <= 1'b0;
         short_reg     <= 1'b0;
      end else if (load) begin
         short_reg     <= short_mode;
         addr_reg      <= short_mode ? (load_addr & SHORT_MAX) : load_addr;
         remaining_reg <= load_count;
         wrap_reg      <= 1'b0;
      end else if (step) begin
         remaining_reg <= remaining_reg - CW'(1);
         if (at_top) begin
            addr_reg <= '0;
            wrap_reg <= 1'b1;
         end else begin
            addr_reg <= addr_reg + AW'(1);
         end
      end
   end

endmodule

// File: rtl/weight_buffer_stream_write_control.sv
// Weight/bias buffer write controller: takes a burst command, consumes a
// valid/ready word stream and emits registered per-bank write strobes, with
// multicast to several weight line buffers and done/error status.
module weight_buffer_stream_write_control
   import weight_write_pkg::*;
#(
   parameter int DATA_WIDTH                    = 64,
   parameter int WEIGHT_LINE_BUFFER_DEPTH      = 512,
   parameter int WEIGHT_BUFFER_BANK_COUNT      = 8,
   parameter int NUMBER_OF_WEIGHT_LINE_BUFFERS = 4,
   parameter int BIAS_LINE_BUFFER_DEPTH        = 64,
   parameter int BIAS_BUFFER_BANK_COUNT        = 2,
   localparam int WBS   = $clog2(WEIGHT_BUFFER_BANK_COUNT),
   localparam int WLA   = $clog2(WEIGHT_LINE_BUFFER_DEPTH),
   localparam int BBS   = $clog2(BIAS_BUFFER_BANK_COUNT),
   localparam int BLA   = $clog2(BIAS_LINE_BUFFER_DEPTH),
   localparam int WADDR = WLA + WBS,
   localparam int CNT   = $clog2(WEIGHT_LINE_BUFFER_DEPTH * WEIGHT_BUFFER_BANK_COUNT + 1),
   localparam int NLB   = NUMBER_OF_WEIGHT_LINE_BUFFERS,
   localparam int WBC   = WEIGHT_BUFFER_BANK_COUNT,
   localparam int BBC   = BIAS_BUFFER_BANK_COUNT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic                  i_cmd_bias,
   input  logic [NLB-1:0]        i_cmd_lb_mask,
   input  logic [WADDR-1:0]      i_cmd_base_addr,
   input  logic [CNT-1:0]        i_cmd_word_count,
   input  logic                  i_data_valid,
   output logic                  o_data_ready,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_data_last,
   output logic [NLB*DATA_WIDTH-1:0] o_write_port_data_in,
   output logic [NLB*WLA-1:0]    o_write_port_addr,
   output logic [NLB-1:0]        o_write_port_enable,
   output logic [NLB*WBC-1:0]    o_write_port_wen,
   output logic [DATA_WIDTH-1:0] o_bias_write_port_data_in,
   output logic [BLA-1:0]        o_bias_write_port_addr,
   output logic                  o_bias_write_port_enable,
   output logic [BBC-1:0]        o_bias_write_port_wen,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [1:0]            o_error
);

   state_t          state_reg;
   logic            cmd_ready_reg;
   logic            data_ready_reg;
   logic            busy_reg;
   logic            done_reg;
   logic [1:0]      error_reg;
   logic            bias_reg;
   logic [NLB-1:0]  mask_reg;

   cmd_t            cmd_in;
   logic            cmd_accept;
   logic            beat;
   logic            final_beat;
   logic            len_mismatch;
   logic [WADDR-1:0] cur_addr;
   logic            last_word;
   logic            wrap_flag;

   // Incoming command gathered into one record.
   always_comb begin
      cmd_in            = '0;
      cmd_in.bias       = i_cmd_bias;
      cmd_in.mask       = PKG_LB_COUNT'(i_cmd_lb_mask);
      cmd_in.base_addr  = PKG_ADDR_W'(i_cmd_base_addr);
      cmd_in.word_count = PKG_CNT_W'(i_cmd_word_count);
   end

   assign cmd_accept   = i_cmd_valid & cmd_ready_reg;
   assign beat         = i_data_valid & data_ready_reg;
   // A burst ends on whichever comes first: count exhausted or last marker.
   assign final_beat   = beat & (last_word | i_data_last);
   assign len_mismatch = last_word ^ i_data_last;

   weight_write_addr_gen #(
      .AW  (WADDR),
      .SAW (BBS + BLA),
      .CW  (CNT)
   ) u_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .load       (cmd_accept),
      .short_mode (cmd_in.bias),
      .load_addr  (WADDR'(cmd_in.base_addr)),
      .load_count (CNT'(cmd_in.word_count)),
      .step       (beat),
      .addr       (cur_addr),
      .last_word  (last_word),
      .wrap_flag  (wrap_flag)
   );

   // Controller FSM with registered handshake and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         cmd_ready_reg  <= 1'b0;
         data_ready_reg <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         error_reg      <= 2'b00;
         bias_reg       <= 1'b0;
         mask_reg       <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               cmd_ready_reg <= 1'b1;
               if (cmd_accept) begin
                  cmd_ready_reg <= 1'b0;
                  busy_reg      <= 1'b1;
                  error_reg     <= 2'b00;
                  bias_reg      <= cmd_in.bias;
                  mask_reg      <= NLB'(cmd_in.mask);
                  if (cmd_in.word_count == '0) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg      <= WRITE;
                     data_ready_reg <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (final_beat) begin
                  state_reg             <= DONE;
                  data_ready_reg        <= 1'b0;
                  done_reg              <= 1'b1;
                  error_reg[ERR_WRAP]   <= wrap_flag;
                  error_reg[ERR_LENGTH] <= len_mismatch;
               end
            end
            DONE: begin
               state_reg     <= IDLE;
               busy_reg      <= 1'b0;
               cmd_ready_reg <= 1'b1;
            end
            default: begin
               state_reg      <= IDLE;
               data_ready_reg <= 1'b0;
               busy_reg       <= 1'b0;
            end
         endcase
      end
   end

   assign o_cmd_ready  = cmd_ready_reg;
   assign o_data_ready = data_ready_reg;
   assign o_busy       = busy_reg;
   assign o_done       = done_reg;
   assign o_error      = error_reg;

   logic [DATA_WIDTH-1:0] lb_data_reg [NLB];
   logic [WLA-1:0]        lb_addr_reg [NLB];
   logic [WBC-1:0]        lb_wen_reg  [NLB];
   logic [NLB-1:0]        lb_en_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NLB; gi++) begin : g_lb
         // One write per accepted beat to each selected line buffer, zero otherwise.
         always_ff @(posedge clk) begin
            if (reset) begin
               lb_en_reg[gi]   <= 1'b0;
               lb_data_reg[gi] <= '0;
               lb_addr_reg[gi] <= '0;
               lb_wen_reg[gi]  <= '0;
            end else if (beat && !bias_reg && mask_reg[gi]) begin
               lb_en_reg[gi]   <= 1'b1;
               lb_data_reg[gi] <= i_data;
               lb_addr_reg[gi] <= cur_addr[WADDR-1:WBS];
               lb_wen_reg[gi]  <= WBC'(1) << cur_addr[WBS-1:0];
            end else begin
               lb_en_reg[gi]   <= 1'b0;
               lb_data_reg[gi] <= '0;
               lb_addr_reg[gi] <= '0;
               lb_wen_reg[gi]  <= '0;
            end
         end

         assign o_write_port_data_in[gi*DATA_WIDTH +: DATA_WIDTH] = lb_data_reg[gi];
         assign o_write_port_addr[gi*WLA +: WLA]                   = lb_addr_reg[gi];
         assign o_write_port_wen[gi*WBC +: WBC]                    = lb_wen_reg[gi];
         assign o_write_port_enable[gi]                            = lb_en_reg[gi];
      end
   endgenerate

   logic [DATA_WIDTH-1:0] bias_data_reg;
   logic [BLA-1:0]        bias_addr_reg;
   logic [BBC-1:0]        bias_wen_reg;
   logic                  bias_en_reg;

   // Bias bank write per accepted beat when the bias buffer is targeted.
   always_ff @(posedge clk) begin
      if (reset) begin
         bias_en_reg   <= 1'b0;
         bias_data_reg <= '0;
         bias_addr_reg <= '0;
         bias_wen_reg  <= '0;
      end else if (beat && bias_reg) begin
         bias_en_reg   <= 1'b1;
         bias_data_reg <= i_data;
         bias_addr_reg <= cur_addr[BBS+BLA-1:BBS];
         bias_wen_reg  <= BBC'(1) << cur_addr[BBS-1:0];
      end else begin
         bias_en_reg   <= 1'b0;
         bias_data_reg <= '0;
         bias_addr_reg <= '0;
         bias_wen_reg  <= '0;
      end
   end

   assign o_bias_write_port_data_in = bias_data_reg;
   assign o_bias_write_port_addr    = bias_addr_reg;
   assign o_bias_write_port_enable  = bias_en_reg;
   assign o_bias_write_port_wen     = bias_wen_reg;

endmodule

// File: tb/tb_weight_buffer_stream_write_control.sv
// Bench for the weight/bias buffer write controller: a table of directed
// bursts, randomized bursts, and a mid-burst reset, all checked cycle by cycle
// against address arithmetic computed here.
module tb_weight_buffer_stream_write_control;

   localparam int DW    = 64;
   localparam int NLB   = 4;
   localparam int WLA   = 9;
   localparam int WBC   = 8;
   localparam int BLA   = 6;
   localparam int BBC   = 2;
   localparam int WSPAN = 512 * 8;
   localparam int BSPAN = 64 * 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              i_cmd_valid;
   logic              o_cmd_ready;
   logic              i_cmd_bias;
   logic [NLB-1:0]    i_cmd_lb_mask;
   logic [11:0]       i_cmd_base_addr;
   logic [12:0]       i_cmd_word_count;
   logic              i_data_valid;
   logic              o_data_ready;
   logic [DW-1:0]     i_data;
   logic              i_data_last;
   logic [NLB*DW-1:0] o_write_port_data_in;
   logic [NLB*WLA-1:0] o_write_port_addr;
   logic [NLB-1:0]    o_write_port_enable;
   logic [NLB*WBC-1:0] o_write_port_wen;
   logic [DW-1:0]     o_bias_write_port_data_in;
   logic [BLA-1:0]    o_bias_write_port_addr;
   logic              o_bias_write_port_enable;
   logic [BBC-1:0]    o_bias_write_port_wen;
   logic              o_busy;
   logic              o_done;
   logic [1:0]        o_error;

   always #5 clk = ~clk;

   weight_buffer_stream_write_control dut (
      .clk                       (clk),
      .reset                     (reset),
      .i_cmd_valid               (i_cmd_valid),
      .o_cmd_ready               (o_cmd_ready),
      .i_cmd_bias                (i_cmd_bias),
      .i_cmd_lb_mask             (i_cmd_lb_mask),
      .i_cmd_base_addr           (i_cmd_base_addr),
      .i_cmd_word_count          (i_cmd_word_count),
      .i_data_valid              (i_data_valid),
      .o_data_ready              (o_data_ready),
      .i_data                    (i_data),
      .i_data_last               (i_data_last),
      .o_write_port_data_in      (o_write_port_data_in),
      .o_write_port_addr         (o_write_port_addr),
      .o_write_port_enable       (o_write_port_enable),
      .o_write_port_wen          (o_write_port_wen),
      .o_bias_write_port_data_in (o_bias_write_port_data_in),
      .o_bias_write_port_addr    (o_bias_write_port_addr),
      .o_bias_write_port_enable  (o_bias_write_port_enable),
      .o_bias_write_port_wen     (o_bias_write_port_wen),
      .o_busy                    (o_busy),
      .o_done                    (o_done),
      .o_error                   (o_error)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit          bias;
      logic [3:0]  mask;
      int          base;
      int          count;
      int          last_at;   // 1-based beat carrying i_data_last, 0 = never
      logic [1:0]  err;       // expected o_error with o_done
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every write output against the write expected for word index waddr.
   task automatic check_outputs(input bit v, input bit bias, input logic [3:0] mask,
                                input logic [DW-1:0] d, input int waddr,
                                input bit exp_done, input logic [1:0] exp_err);
      logic [NLB*DW-1:0]  e_data;
      logic [NLB*WLA-1:0] e_addr;
      logic [NLB-1:0]     e_en;
      logic [NLB*WBC-1:0] e_wen;
      logic [DW-1:0]      eb_data;
      logic [BLA-1:0]     eb_addr;
      logic               eb_en;
      logic [BBC-1:0]     eb_wen;
      e_data = '0; e_addr = '0; e_en = '0; e_wen = '0;
      eb_data = '0; eb_addr = '0; eb_en = 1'b0; eb_wen = '0;
      if (v && !bias) begin
         for (int i = 0; i < NLB; i++) begin
            if (mask[i]) begin
               e_data[i*DW +: DW]   = d;
               e_addr[i*WLA +: WLA] = WLA'(waddr / WBC);
               e_en[i]              = 1'b1;
               e_wen[i*WBC + (waddr % WBC)] = 1'b1;
            end
         end
      end
      if (v && bias) begin
         eb_data = d;
         eb_addr = BLA'(waddr / BBC);
         eb_en   = 1'b1;
         eb_wen[waddr % BBC] = 1'b1;
      end
      check("lb_data", 256'(o_write_port_data_in), 256'(e_data));
      check("lb_addr", 256'(o_write_port_addr), 256'(e_addr));
      check("lb_enable", 256'(o_write_port_enable), 256'(e_en));
      check("lb_wen", 256'(o_write_port_wen), 256'(e_wen));
      check("bias_data", 256'(o_bias_write_port_data_in), 256'(eb_data));
      check("bias_addr", 256'(o_bias_write_port_addr), 256'(eb_addr));
      check("bias_enable", 256'(o_bias_write_port_enable), 256'(eb_en));
      check("bias_wen", 256'(o_bias_write_port_wen), 256'(eb_wen));
      check("done", 256'(o_done), 256'(exp_done));
      if (exp_done) check("error", 256'(o_error), 256'(exp_err));
   endtask

   // Run one burst; entered and left at #1 after a rising edge.
   task automatic burst(input string tag, input bit bias, input logic [3:0] mask,
                        input int base, input int count, input int last_at,
                        input logic [1:0] exp_err, input int valid_pct, input int abort_after);
      int span;
      int start;
      int nbeats;
      int k;
      int guard;
      int waitc;
      bit v;
      bit fin;
      logic [DW-1:0] d;
      span   = bias ? BSPAN : WSPAN;
      start  = base % span;
      nbeats = (count == 0) ? 0 : ((last_at >= 1 && last_at < count) ? last_at : count);
      k = 0; guard = 0; waitc = 0;

      while (!o_cmd_ready && waitc < 8) begin
         @(posedge clk); #1;
         waitc++;
      end
      check("cmd_ready_idle", 256'(o_cmd_ready), 256'(1));

      i_cmd_valid      = 1'b1;
      i_cmd_bias       = bias;
      i_cmd_lb_mask    = mask;
      i_cmd_base_addr  = 12'(base);
      i_cmd_word_count = 13'(count);
      @(posedge clk); #1;
      i_cmd_valid      = 1'b0;
      i_cmd_lb_mask    = 4'($urandom);
      i_cmd_base_addr  = 12'($urandom);
      check("busy_after_accept", 256'(o_busy), 256'(1));
      check("cmd_ready_after_accept", 256'(o_cmd_ready), 256'(0));

      if (nbeats == 0) begin
         check_outputs(1'b0, bias, mask, '0, 0, 1'b1, exp_err);
         check("data_ready_zero_count", 256'(o_data_ready), 256'(0));
      end else begin
         while (k < nbeats && guard < 2000) begin
            v = ($urandom_range(99) < valid_pct);
            d = {$urandom, $urandom};
            i_data_valid = v;
            i_data       = d;
            i_data_last  = (k + 1 == last_at);
            check("data_ready", 256'(o_data_ready), 256'(1));
            @(posedge clk); #1;
            fin = v && (k + 1 == nbeats);
            check_outputs(v, bias, mask, d, (start + k) % span, fin, exp_err);
            if (v) k++;
            guard++;
            if (abort_after != 0 && k == abort_after && !fin) begin
               // Reset lands while beats are still being offered.
               reset        = 1'b1;
               i_data_valid = 1'b1;
               i_data       = {$urandom, $urandom};
               @(posedge clk); #1;
               check_outputs(1'b0, bias, mask, '0, 0, 1'b0, 2'b00);
               check("busy_in_reset", 256'(o_busy), 256'(0));
               check("cmd_ready_in_reset", 256'(o_cmd_ready), 256'(0));
               check("data_ready_in_reset", 256'(o_data_ready), 256'(0));
               reset        = 1'b0;
               @(posedge clk); #1;
               check_outputs(1'b0, bias, mask, '0, 0, 1'b0, 2'b00);
               i_data_valid = 1'b0;
               check("cmd_ready_after_reset", 256'(o_cmd_ready), 256'(1));
               $display("burst %s: aborted by reset after %0d beats", tag, k);
               return;
            end
         end
         i_data_valid = 1'b0;
         i_data_last  = 1'b0;
         check("beats_consumed", 256'(k), 256'(nbeats));
         check("data_ready_after_end", 256'(o_data_ready), 256'(0));
         check("busy_in_done", 256'(o_busy), 256'(1));
      end

      // Cycle after the done pulse: idle again, no writes, ready for a command.
      @(posedge clk); #1;
      check_outputs(1'b0, bias, mask, '0, 0, 1'b0, 2'b00);
      check("cmd_ready_after_done", 256'(o_cmd_ready), 256'(1));
      check("busy_after_done", 256'(o_busy), 256'(0));
      $display("burst %s: bias=%0d mask=%b base=%0d count=%0d last_at=%0d beats=%0d err_exp=%b",
               tag, bias, mask, base, count, last_at, nbeats, exp_err);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          rb;
      logic [3:0]  rm;
      int          rbase;
      int          rcount;
      int          rlast;
      int          rsel;
      int          rspan;
      int          rn;
      logic [1:0]  rerr;

      vecs[0] = '{bias: 1'b0, mask: 4'b0001, base: 0,    count: 16, last_at: 16, err: 2'b00};
      vecs[1] = '{bias: 1'b0, mask: 4'b1010, base: 13,   count: 4,  last_at: 4,  err: 2'b00};
      vecs[2] = '{bias: 1'b1, mask: 4'b1111, base: 5,    count: 3,  last_at: 3,  err: 2'b00};
      vecs[3] = '{bias: 1'b0, mask: 4'b0001, base: 0,    count: 5,  last_at: 2,  err: 2'b01};
      vecs[4] = '{bias: 1'b0, mask: 4'b0001, base: 4095, count: 2,  last_at: 2,  err: 2'b10};
      vecs[5] = '{bias: 1'b0, mask: 4'b0001, base: 0,    count: 0,  last_at: 0,  err: 2'b00};
      vecs[6] = '{bias: 1'b0, mask: 4'b0000, base: 100,  count: 3,  last_at: 3,  err: 2'b00};
      vecs[7] = '{bias: 1'b0, mask: 4'b0100, base: 20,   count: 3,  last_at: 0,  err: 2'b01};
      vecs[8] = '{bias: 1'b1, mask: 4'b0000, base: 127,  count: 2,  last_at: 2,  err: 2'b10};

      reset            = 1'b1;
      i_cmd_valid      = 1'b0;
      i_cmd_bias       = 1'b0;
      i_cmd_lb_mask    = '0;
      i_cmd_base_addr  = '0;
      i_cmd_word_count = '0;
      i_data_valid     = 1'b0;
      i_data           = '0;
      i_data_last      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs(1'b0, 1'b0, 4'b0, '0, 0, 1'b0, 2'b00);
      check("reset_cmd_ready", 256'(o_cmd_ready), 256'(0));
      check("reset_busy", 256'(o_busy), 256'(0));
      check("reset_error", 256'(o_error), 256'(0));
      reset = 1'b0;
      @(posedge clk); #1;
      check("cmd_ready_post_reset", 256'(o_cmd_ready), 256'(1));
      check("busy_post_reset", 256'(o_busy), 256'(0));
      $display("reset: done");

      for (int i = 0; i < 9; i++) begin
         burst($sformatf("vec%0d", i), vecs[i].bias, vecs[i].mask, vecs[i].base,
               vecs[i].count, vecs[i].last_at, vecs[i].err, 100, 0);
      end

      // Gapped stream on a multicast burst, then an abort mid-burst.
      burst("gapped", 1'b0, 4'b0110, 2040, 10, 10, 2'b00, 50, 0);
      burst("abort", 1'b0, 4'b1111, 300, 8, 8, 2'b00, 60, 3);
      burst("after_abort", 1'b1, 4'b0000, 64, 4, 4, 2'b00, 100, 0);

      for (int r = 0; r < 25; r++) begin
         rb     = ($urandom_range(3) == 0);
         rm     = 4'($urandom);
         rcount = $urandom_range(0, 12);
         if (rb)
            rbase = $urandom_range(0, 31) * BSPAN +
                    (($urandom_range(2) == 0) ? (BSPAN - 1 - $urandom_range(0, 5)) : $urandom_range(0, BSPAN - 1));
         else
            rbase = ($urandom_range(2) == 0) ? (WSPAN - 1 - $urandom_range(0, 5)) : $urandom_range(0, WSPAN - 1);
         rsel  = $urandom_range(2);
         rlast = (rsel == 0) ? rcount : ((rsel == 1) ? $urandom_range(1, rcount + 2) : 0);
         rspan = rb ? BSPAN : WSPAN;
         rn    = (rcount == 0) ? 0 : ((rlast >= 1 && rlast < rcount) ? rlast : rcount);
         rerr[0] = (rcount != 0) && (rlast != rcount);
         rerr[1] = (rn > 0) && ((rbase % rspan) + rn >= rspan);
         burst($sformatf("rand%0d", r), rb, rm, rbase, rcount, rlast, rerr, 70, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/weight_buffer_stream_write_control.md
Name: weight_buffer_stream_write_control

Overview:
Next-generation weight/bias buffer write controller. Accepts a write command (target, line-buffer mask, base word address, word count), then a valid/ready data stream, and generates registered per-line-buffer and bias write strobes with auto-incrementing bank/address. Adds multicast to several line buffers, burst length checking and completion/error status. Sits between the weight DMA front-end and the weight/bias line-buffer banks.

Parameters:
DATA_WIDTH, 64, bits per word written to one bank
WEIGHT_LINE_BUFFER_DEPTH, 512, words per bank per weight line buffer
WEIGHT_BUFFER_BANK_COUNT, 8, banks per weight line buffer, power of two
NUMBER_OF_WEIGHT_LINE_BUFFERS, 4, weight line buffers
BIAS_LINE_BUFFER_DEPTH, 64, words per bias bank
BIAS_BUFFER_BANK_COUNT, 2, bias banks, power of two
Derived (localparam): WBS=$clog2(WEIGHT_BUFFER_BANK_COUNT), WLA=$clog2(WEIGHT_LINE_BUFFER_DEPTH), BBS, BLA likewise; WADDR=WLA+WBS; CNT=$clog2(WEIGHT_LINE_BUFFER_DEPTH*WEIGHT_BUFFER_BANK_COUNT+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  high only in IDLE
i_cmd_bias  in  1  1=bias buffer target, 0=weight line buffers
i_cmd_lb_mask  in  NUMBER_OF_WEIGHT_LINE_BUFFERS  weight line buffers written (multicast); ignored for bias
i_cmd_base_addr  in  WADDR  start word address; [WBS-1:0]=bank, upper=line address (bias uses low BBS+BLA bits)
i_cmd_word_count  in  CNT  words in burst
i_data_valid  in  1  stream beat valid
o_data_ready  out  1  high only in WRITE
i_data  in  DATA_WIDTH  beat payload
i_data_last  in  1  final beat marker
o_write_port_data_in  out  NUMBER_OF_WEIGHT_LINE_BUFFERS x DATA_WIDTH  weight write data
o_write_port_addr  out  NUMBER_OF_WEIGHT_LINE_BUFFERS x WLA  weight line address
o_write_port_enable  out  NUMBER_OF_WEIGHT_LINE_BUFFERS  weight port enable
o_write_port_wen  out  NUMBER_OF_WEIGHT_LINE_BUFFERS x WEIGHT_BUFFER_BANK_COUNT  one-hot bank write enable
o_bias_write_port_data_in  out  DATA_WIDTH  bias write data
o_bias_write_port_addr  out  BLA  bias line address
o_bias_write_port_enable  out  1  bias port enable
o_bias_write_port_wen  out  BIAS_BUFFER_BANK_COUNT  one-hot bias bank enable
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse at burst end
o_error  out  2  [0]=length mismatch, [1]=address wrap; valid with o_done

Behaviour:
- Reset: state IDLE; all write outputs, o_done, o_error, o_busy = 0; o_cmd_ready=1 one cycle after reset deasserts. Reset mid-burst aborts immediately, no further writes, no o_done.
- FSM IDLE -> WRITE on i_cmd_valid&&o_cmd_ready; command latched. count==0: IDLE -> DONE directly, no writes, error=0.
- WRITE: beat accepted when i_data_valid&&o_data_ready. Per beat: write current address, address+=1, remaining-=1.
- Address is linear word index: bank = low bits, line = upper bits; consecutive beats walk all banks of a line before incrementing line.
- Wrap: increment past last word (WADDR or BBS+BLA bits all ones) wraps to 0, sets sticky error[1]; writing continues.
- Exit WRITE -> DONE on the beat where remaining reaches 0 or i_data_last=1, whichever first. error[0]=1 if the two do not coincide (early last, or count exhausted without last).
- DONE: o_done=1 one cycle, o_error reported, -> IDLE. Errors cleared on next command accept.
- Write latency: outputs registered, exactly one cycle after beat acceptance; enable and wen asserted for that single cycle; all fields zero on idle cycles (no stale data).
- Weight target: every line buffer i with mask[i]=1 receives identical data/addr/enable/wen; others zero. Mask all-zero: beats consumed, no writes. Bias target: weight outputs zero.
- Back-to-back beats sustain one write per cycle; i_data_valid low inserts bubbles without state change.
- Minimum gap between bursts: 2 cycles (DONE, IDLE).

Decomposition:
- Shared package weight_write_pkg: command struct typedef (bias, mask, base_addr, word_count), error bit index constants, state enum (IDLE, WRITE, DONE).
- One sub-module: weight_write_addr_gen (loadable address counter + remaining counter, wrap flag).

Test Plan:
- Weight burst base=0, count=16, mask=4'b0001, last on beat 16 -> LB0 wen one-hot banks 0..7 on addr 0 then 1, each one cycle after accept; o_done, error=0.
- Multicast mask=4'b1010, base=13, count=4 -> LB1 and LB3 get identical writes bank5/addr1, bank6, bank7, bank0/addr2; LB0/LB2 outputs zero.
- Bias burst base=5, count=3 -> bias bank1/addr2, bank0/addr3, bank1/addr3; weight enables never asserted.
- i_data_last on beat 2 of count=5 -> 2 writes, o_done, error=2'b01; next command accepted 2 cycles later.
- Weight base=4095, count=2 -> writes addr511/bank7 then addr0/bank0, error=2'b10; count=0 -> o_done without writes.
- Reset asserted after 3 of 8 beats, random valid gaps throughout -> outputs zero next cycle, no o_done, o_cmd_ready=1 after reset.
